// File: rtl/conv_bcd_bin.sv
// rtl/conv_bcd_bin.sv - sequential BCD-to-binary converter (reverse double dabble)
module conv_bcd_bin #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BIN_W-1:0]      bin_out
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam longint MAX_BCD = longint'(10 ** DIGITS) - 1;
  localparam longint BIN_SPAN = longint'(1) << BIN_W;

  generate
    if (BIN_SPAN <= MAX_BCD) begin : g_param_check
      $error("conv_bcd_bin: BIN_W too small for DIGITS");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [BCD_W-1:0]     bcd_r, bcd_nxt;
  logic [BIN_W-1:0]     bin_r, bin_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [BIN_W-1:0]     bin_out_nxt;
  logic                 err_nxt;

  logic [BCD_W+BIN_W-1:0] shifted;
  logic [BCD_W-1:0]       bcd_sh, bcd_cor;
  logic [BIN_W-1:0]       bin_sh;
  logic                   bad_digit;

  // One reverse-dabble step: shift right, then pull every digit >= 8 back by 3.
  assign shifted = {bcd_r, bin_r} >> 1;
  assign bcd_sh  = shifted[BCD_W+BIN_W-1:BIN_W];
  assign bin_sh  = shifted[BIN_W-1:0];

  always_comb begin
    bcd_cor = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) bcd_cor[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign busy = (state == CONV);
  assign done = (state == DONE);

  always_comb begin
    state_nxt   = state;
    bcd_nxt     = bcd_r;
    bin_nxt     = bin_r;
    cnt_nxt     = cnt;
    bin_out_nxt = bin_out;
    err_nxt     = err;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            state_nxt   = DONE;
            err_nxt     = 1'b1;
            bin_out_nxt = '0;
          end else begin
            state_nxt = CONV;
            bcd_nxt   = bcd_in;
            bin_nxt   = '0;
            cnt_nxt   = '0;
          end
        end
      end
      CONV: begin
        bcd_nxt = bcd_cor;
        bin_nxt = bin_sh;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          state_nxt   = DONE;
          bin_out_nxt = bin_sh;
          err_nxt     = 1'b0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bcd_r   <= '0;
      bin_r   <= '0;
      cnt     <= '0;
      bin_out <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      bcd_r   <= bcd_nxt;
      bin_r   <= bin_nxt;
      cnt     <= cnt_nxt;
      bin_out <= bin_out_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_conv_bcd_bin.sv
// tb/tb_conv_bcd_bin.sv - scoreboard bench for conv_bcd_bin
module tb_conv_bcd_bin;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [4*DIGITS-1:0] bcd_in = '0;
  logic                busy, done, err;
  logic [BIN_W-1:0]    bin_out;

  conv_bcd_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .busy(busy), .done(done), .err(err), .bin_out(bin_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned bin;
    bit          err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Decimal value of the packed digits; invalid if any digit exceeds 9.
  function automatic void model(input logic [4*DIGITS-1:0] b, output int v, output bit bad);
    int d;
    v = 0;
    bad = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    if (bad) v = 0;
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("bin_out", int'(bin_out), int'(mon_e.bin));
        check("err", int'(err), int'(mon_e.err));
        check("done_cycle", cyc, mon_e.cyc);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic run_op(input logic [4*DIGITS-1:0] b, input int inj_at,
                        input logic [4*DIGITS-1:0] inj_bcd);
    int  v;
    bit  bad;
    int  nbusy;
    bit  seen;
    exp_t e;
    model(b, v, bad);
    @(negedge clk);
    start  = 1'b1;
    bcd_in = b;
    e.bin = v;
    e.err = bad;
    e.cyc = cyc + 1 + (bad ? 0 : BIN_W);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    bcd_in = $urandom_range(0, 4095);
    nbusy = 0;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
      if (k == inj_at) begin
        start  = 1'b1;
        bcd_in = inj_bcd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", int'(seen), 1);
    check("busy_cycles", nbusy, bad ? 0 : BIN_W);
    @(negedge clk);
    check("done_pulse_width", int'(done), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4*DIGITS-1:0] rb;
    int dig;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    check("reset_bin_out", int'(bin_out), 0);

    run_op(12'h999, -1, '0);
    repeat (5) @(negedge clk);
    check("hold_bin_out", int'(bin_out), 999);

    run_op(12'h000, -1, '0);
    run_op(12'h255, -1, '0);
    run_op(12'h512, -1, '0);

    run_op(12'h1A5, -1, '0);
    run_op(12'h042, -1, '0);

    run_op(12'h123, 2, 12'h777);
    repeat (3) @(negedge clk);
    check("hold_after_ignored_start", int'(bin_out), 123);

    // Abort a conversion with reset on the fifth edge after acceptance.
    @(negedge clk);
    start  = 1'b1;
    bcd_in = 12'h999;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", int'(busy), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_err", int'(err), 0);
    check("abort_bin_out", int'(bin_out), 0);
    start  = 1'b1;
    bcd_in = 12'h456;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    repeat (14) @(negedge clk);
    check("abort_idle_busy", int'(busy), 0);
    run_op(12'h300, -1, '0);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        dig = $urandom_range(0, 9);
        if ($urandom_range(0, 9) == 0) dig = $urandom_range(10, 15);
        rb[4*i +: 4] = 4'(dig);
      end
      run_op(rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1,
             12'($urandom_range(0, 4095)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_bcd_bin.md
# conv_bcd_bin

Sequential BCD-to-binary converter using reverse double dabble: shift right, then subtract 3 from every BCD digit that reads 8 or more. It is the inverse of the add-3 binary-to-BCD correction path in the ASCII adder datapath. It takes the packed BCD operand assembled from decoded ASCII digits and returns its binary value to the adder. A start/busy/done handshake lets the control FSM launch one conversion at a time.

## Interface
Parameters:
- DIGITS, 3, number of packed BCD digits at the input.
- BIN_W, 10, binary result width; must satisfy 2^BIN_W > 10^DIGITS - 1 (elaboration-time check).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  conversion request; accepted only in IDLE.
- bcd_in  input  4*DIGITS  packed BCD operand, most significant digit in the top nibble; sampled only on the accepting edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when the result (or the error) is valid.
- err  output  1  high when the accepted operand had any nibble greater than 9.
- bin_out  output  BIN_W  binary result.

## Operation
- Reset values: state IDLE; busy=0, done=0, err=0, bin_out=0; internal shift registers and iteration counter cleared.
- Internal registers:
  - bcd_r, 4*DIGITS bits.
  - bin_r, BIN_W bits.
  - cnt, wide enough to hold BIN_W.
- FSM states are IDLE, CONV and DONE.
- IDLE, start=1, all nibbles of bcd_in ≤ 9: load bcd_r=bcd_in, bin_r=0, cnt=0, then go to CONV.
- IDLE, start=1, any nibble > 9: go directly to DONE with err=1 and bin_out=0. No iterations are run.
- IDLE, start=0: remain in IDLE; outputs hold.
- CONV, one iteration per clock:
  - Shift the concatenation {bcd_r, bin_r} right by one bit. The bcd_r LSB enters the bin_r MSB, and 0 enters the bcd_r MSB.
  - After the shift, for every nibble of bcd_r: if the nibble ≥ 8, subtract 3 (4-bit, no borrow between nibbles).
  - Increment cnt. When the iteration that brings cnt to BIN_W completes, go to DONE and register bin_out from the post-iteration bin_r, with err=0.
- DONE: done=1 for exactly this one cycle, then return to IDLE.
- bin_out and err hold their values until the next accepted start changes them. They are not cleared on return to IDLE.
- start is ignored in CONV and DONE. It is not queued, and bcd_in changes during a conversion have no effect.
- After BIN_W iterations bcd_r is 0 for every valid input. No overflow case exists given the parameter constraint.

## Timing
- Let E0 be the rising edge on which start is accepted in IDLE.
- Valid operand:
  - busy=1 in the cycles following E0 through E(BIN_W-1).
  - The edge E(BIN_W) moves the FSM to DONE. After E(BIN_W): busy=0, done=1, bin_out valid.
  - After E(BIN_W+1): done=0 and the FSM is back in IDLE.
  - Latency is BIN_W+1 clocks from start to done; with defaults, 11.
- Invalid operand:
  - After E0: done=1, err=1, bin_out=0, busy=0.
  - After E1: back in IDLE.
- The earliest next accept is the edge following the done cycle. Back-to-back throughput is one result per BIN_W+2 clocks.
- rst=1 on any edge, including mid-CONV or during DONE, forces the reset values on that edge and aborts the conversion. No done pulse is issued for the aborted operation.
- rst and start high on the same edge: rst wins and start is dropped.

## Test plan
- Reset: hold rst for 2 cycles, then release → busy=0, done=0, err=0, bin_out=0.
- Valid conversion: bcd_in=12'h999 with start pulse → done pulses on the 11th edge after acceptance with bin_out=10'd999 (0x3E7) and err=0; bin_out still 999 five cycles later.
- Boundary operands: bcd_in=12'h000 → bin_out=0; bcd_in=12'h255 → 255 (0xFF); bcd_in=12'h512 → 512 (0x200). Each completes with the same 11-clock latency.
- Invalid operand: bcd_in=12'h1A5 with start → done and err high on the edge after acceptance, bin_out=0; a following valid start with 12'h042 → bin_out=42, err=0.
- Start during busy: accept 12'h123, then pulse start with bcd_in=12'h777 three cycles later → exactly one done pulse, bin_out=123, busy waveform unchanged.
- Reset mid-operation: accept 12'h999, assert rst on the 5th edge → all outputs at reset values, no done pulse; a new start with 12'h300 after reset release → bin_out=300.
